lcd_write_arbiter: RTL and testbench

Shares the 4-bit HD44780 LCD bus between two byte-level requesters once the power-on init sequencer has finished. Each accepted byte becomes two enable-strobed nibble writes (high nibble first), with an extra settle wait after clear/home commands. Sits between the init sequencer, which drives `init_done`, and the LCD pins. Timing assumes the 1 kHz (1 ms) system clock used by the LCD path.

---
 rtl/lcd_write_arbiter.sv | 119 +++++++++++
 tb/tb_lcd_write_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter that turns accepted bytes from two requesters into
// HD44780 4-bit nibble writes, with a settle wait after clear/home commands.
module lcd_write_arbiter #(
  parameter int unsigned CLEAR_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_done_i,
  input  logic       req0_valid_i,
  input  logic       req0_rs_i,
  input  logic [7:0] req0_data_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic       req1_rs_i,
  input  logic [7:0] req1_data_i,
  output logic       req1_ready_o,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic [3:0] lcd_data_o,
  output logic       busy_o,
  output logic       last_grant_o
);

  localparam logic [7:0] ClearWait = 8'(CLEAR_WAIT);

  // The low-nibble disable phase overlaps the first IDLE/WAIT cycle, which is
  // what gives one byte per 4 cycles.
  typedef enum logic [2:0] {
    StIdle,
    StHiEn,
    StHiDis,
    StLoEn,
    StWait
  } state_e;

  state_e     state_q;
  logic       lcd_en_q, lcd_rs_q, last_grant_q;
  logic [3:0] lcd_data_q;
  logic [7:0] byte_q, cnt_q;
  logic       rs_q;

  logic       can_accept, gnt_idx, accept, sel_rs, is_long;
  logic [7:0] sel_data;

  always_comb begin
    can_accept = (state_q == StIdle) && init_done_i && !reset;
    if (req0_valid_i && req1_valid_i) begin
      gnt_idx = ~last_grant_q;
    end else begin
      gnt_idx = req1_valid_i;
    end
    req0_ready_o = can_accept && req0_valid_i && !gnt_idx;
    req1_ready_o = can_accept && req1_valid_i && gnt_idx;
    accept       = req0_ready_o || req1_ready_o;
    sel_rs       = gnt_idx ? req1_rs_i : req0_rs_i;
    sel_data     = gnt_idx ? req1_data_i : req0_data_i;
    // Clear (0x01) and return home (0x02/0x03) need extra settle time.
    is_long      = !rs_q && (byte_q[7:2] == 6'd0) && (byte_q[1:0] != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      lcd_en_q     <= 1'b0;
      lcd_rs_q     <= 1'b0;
      lcd_data_q   <= 4'd0;
      last_grant_q <= 1'b1;
      byte_q       <= 8'd0;
      rs_q         <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            byte_q       <= sel_data;
            rs_q         <= sel_rs;
            last_grant_q <= gnt_idx;
            lcd_en_q     <= 1'b1;
            lcd_rs_q     <= sel_rs;
            lcd_data_q   <= sel_data[7:4];
            state_q      <= StHiEn;
          end
        end
        StHiEn: begin
          lcd_en_q <= 1'b0;
          state_q  <= StHiDis;
        end
        StHiDis: begin
          lcd_en_q   <= 1'b1;
          lcd_data_q <= byte_q[3:0];
          state_q    <= StLoEn;
        end
        StLoEn: begin
          lcd_en_q <= 1'b0;
          if (is_long && (CLEAR_WAIT != 0)) begin
            cnt_q   <= ClearWait;
            state_q <= StWait;
          end else begin
            state_q <= StIdle;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lcd_en_o     = lcd_en_q;
  assign lcd_rs_o     = lcd_rs_q;
  assign lcd_data_o   = lcd_data_q;
  assign busy_o       = (state_q != StIdle);
  assign last_grant_o = last_grant_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed bench for lcd_write_arbiter: init gating, nibble timing, round-robin,
// clear settle wait, mid-byte reset and init_done drop.
module tb_lcd_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       init_done;
  logic       req0_valid, req0_rs, req1_valid, req1_rs;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       lcd_en, lcd_rs, busy, last_grant;
  logic [3:0] lcd_data;

  int n_tests = 0;
  int n_fail  = 0;

  lcd_write_arbiter #(.CLEAR_WAIT(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .init_done_i (init_done),
    .req0_valid_i(req0_valid),
    .req0_rs_i   (req0_rs),
    .req0_data_i (req0_data),
    .req0_ready_o(req0_ready),
    .req1_valid_i(req1_valid),
    .req1_rs_i   (req1_rs),
    .req1_data_i (req1_data),
    .req1_ready_o(req1_ready),
    .lcd_en_o    (lcd_en),
    .lcd_rs_o    (lcd_rs),
    .lcd_data_o  (lcd_data),
    .busy_o      (busy),
    .last_grant_o(last_grant)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  logic [7:0] rr_bytes [4];
  logic       rr_rs    [4];

  initial begin
    int idx0, idx1, b;
    rr_bytes[0] = 8'hA1; rr_rs[0] = 1'b1;
    rr_bytes[1] = 8'hB1; rr_rs[1] = 1'b0;
    rr_bytes[2] = 8'hA2; rr_rs[2] = 1'b1;
    rr_bytes[3] = 8'hB2; rr_rs[3] = 1'b0;

    reset = 1'b1; init_done = 1'b1;
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h48;
    req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h00;

    // Reset state, readys held low even with valid and init_done high.
    next_cycle(); next_cycle(); #1;
    check_eq("rst_ready0", req0_ready, 0);
    check_eq("rst_ready1", req1_ready, 0);
    check_eq("rst_en", lcd_en, 0);
    check_eq("rst_rs", lcd_rs, 0);
    check_eq("rst_data", lcd_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_last_grant", last_grant, 1);

    // init_done low blocks acceptance.
    next_cycle();
    reset = 1'b0; init_done = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("noinit_ready0", req0_ready, 0);
      check_eq("noinit_ready1", req1_ready, 0);
      check_eq("noinit_en", lcd_en, 0);
      check_eq("noinit_busy", busy, 0);
      next_cycle();
    end

    // 'H' = 0x48, rs=1.
    init_done = 1'b1; #1;
    check_eq("h_ready0_T", req0_ready, 1);
    next_cycle(); req0_valid = 1'b0; #1;
    check_eq("h_en_T1", lcd_en, 1);
    check_eq("h_data_T1", lcd_data, 4);
    check_eq("h_rs_T1", lcd_rs, 1);
    check_eq("h_lg_T1", last_grant, 0);
    next_cycle(); #1;
    check_eq("h_en_T2", lcd_en, 0);
    check_eq("h_rs_T2", lcd_rs, 1);
    next_cycle(); #1;
    check_eq("h_en_T3", lcd_en, 1);
    check_eq("h_data_T3", lcd_data, 8);
    next_cycle(); #1;
    check_eq("h_en_T4", lcd_en, 0);
    check_eq("h_busy_T4", busy, 0);
    check_eq("h_data_T4", lcd_data, 8);

    // Round-robin from reset: grants 0,1,0,1, one accept every 4 cycles.
    reset = 1'b1;
    next_cycle(); reset = 1'b0;
    idx0 = 0; idx1 = 0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_rs = 1'b1; req1_rs = 1'b0;
    for (int k = 0; k < 16; k++) begin
      req0_data = (idx0 == 0) ? 8'hA1 : 8'hA2;
      req1_data = (idx1 == 0) ? 8'hB1 : 8'hB2;
      #1;
      b = k / 4;
      check_eq("rr_ready0", req0_ready, (k % 4 == 0) && (b % 2 == 0));
      check_eq("rr_ready1", req1_ready, (k % 4 == 0) && (b % 2 == 1));
      check_eq("rr_en", lcd_en, (k % 4 == 1) || (k % 4 == 3));
      if (k % 4 == 1) begin
        check_eq("rr_hi", lcd_data, rr_bytes[b][7:4]);
        check_eq("rr_rs", lcd_rs, rr_rs[b]);
        check_eq("rr_lg", last_grant, b % 2);
      end
      if (k % 4 == 3) check_eq("rr_lo", lcd_data, rr_bytes[b][3:0]);
      if (req0_ready) idx0++;
      if (req1_ready) idx1++;
      next_cycle();
    end

    // Clear command from req1: busy T+1..T+5, next accept at T+6.
    req0_valid = 1'b0; req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h01; #1;
    check_eq("clr_ready1_T", req1_ready, 1);
    next_cycle(); req1_rs = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      #1;
      check_eq("clr_busy", busy, 1);
      check_eq("clr_ready1", req1_ready, 0);
      next_cycle();
    end
    #1;
    check_eq("clr_busy_T6", busy, 0);
    check_eq("clr_ready1_T6", req1_ready, 1);
    // Same byte as character data: no wait, next accept at T+4.
    next_cycle(); req1_valid = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      #1;
      check_eq("chr_busy", busy, 1);
      next_cycle();
    end
    req1_valid = 1'b1; #1;
    check_eq("chr_ready1_T4", req1_ready, 1);
    next_cycle(); req1_valid = 1'b0;
    next_cycle(); next_cycle(); next_cycle();

    // Reset during LO_EN discards the byte.
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h55; #1;
    check_eq("rl_ready0_T", req0_ready, 1);
    next_cycle(); req0_valid = 1'b0;
    next_cycle(); next_cycle(); #1;
    check_eq("rl_en_T3", lcd_en, 1);
    reset = 1'b1;
    next_cycle(); #1;
    check_eq("rl_en", lcd_en, 0);
    check_eq("rl_data", lcd_data, 0);
    check_eq("rl_rs", lcd_rs, 0);
    check_eq("rl_busy", busy, 0);
    check_eq("rl_lg", last_grant, 1);
    reset = 1'b0; req0_valid = 1'b1; req0_data = 8'h3C; #1;
    check_eq("rl_ready0_after", req0_ready, 1);
    next_cycle(); req0_valid = 1'b0; #1;
    check_eq("rl_en_after", lcd_en, 1);
    check_eq("rl_data_after", lcd_data, 3);
    check_eq("rl_lg_after", last_grant, 0);
    next_cycle(); next_cycle(); next_cycle();

    // init_done drops during HI_DIS: byte completes, then nothing accepted.
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h7E; #1;
    check_eq("id_ready1_T", req1_ready, 1);
    next_cycle(); req1_valid = 1'b0;
    next_cycle(); init_done = 1'b0; req0_valid = 1'b1; req0_data = 8'h20; #1;
    check_eq("id_en_T2", lcd_en, 0);
    next_cycle(); #1;
    check_eq("id_en_T3", lcd_en, 1);
    check_eq("id_lo_T3", lcd_data, 4'hE);
    next_cycle();
    for (int t = 4; t <= 7; t++) begin
      #1;
      check_eq("id_ready0_low", req0_ready, 0);
      check_eq("id_en_low", lcd_en, 0);
      check_eq("id_busy_low", busy, 0);
      next_cycle();
    end
    init_done = 1'b1; #1;
    check_eq("id_ready0_back", req0_ready, 1);
    next_cycle(); req0_valid = 1'b0; #1;
    check_eq("id_hi_back", lcd_data, 2);
    for (int t = 0; t < 5; t++) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
